// File: rtl/norm_pkg.sv
// Shared definitions for the leading-zero normalizer: default width,
// count-width helper and per-stage shift amount.
// Pure package: no latency, no flow control.
package norm_pkg;

    localparam int DATA_W_DEF = 16;

    // The count must hold DATA_W itself (all-zero input), hence the extra bit.
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    // Stage k halves the remaining search window: DATA_W/2, DATA_W/4, ... 1.
    function automatic int stage_shift(input int data_w, input int k);
        return data_w >> (k + 1);
    endfunction

endpackage

// File: rtl/norm_stage.sv
// One normalizer step: if the top SHIFT bits are zero, shift left by SHIFT and add SHIFT to the count.
// Latency: 1 cycle (registered output).
// Backpressure: holds all state while en=0.
// Ports: clk/rst, en (advance), in_valid/in_data/in_cnt from the previous stage,
//        out_valid/out_data/out_cnt registered to the next stage.
module norm_stage #(
    parameter int DATA_W   = 16,
    parameter int CW       = 5,
    parameter int SHIFT    = 8,
    parameter bit ZERO_FIX = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW-1:0]     in_cnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_cnt
);

    logic              top_zero;
    logic [DATA_W-1:0] nxt_data;
    logic [CW-1:0]     nxt_cnt;

    always_comb begin
        top_zero = (in_data[DATA_W-1 -: SHIFT] == '0);
        nxt_data = in_data;
        nxt_cnt  = in_cnt;
        if (top_zero) begin
            nxt_data = in_data << SHIFT;
            nxt_cnt  = in_cnt + CW'(SHIFT);
        end
        // The shift amounts sum to DATA_W-1, so an all-zero word would end one
        // short; the final stage tops the count up to DATA_W.
        if (ZERO_FIX && (nxt_data == '0)) begin
            nxt_cnt = nxt_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= nxt_data;
            out_cnt   <= nxt_cnt;
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// Normalizes a word (shift left until MSB=1) and reports the leading-zero count.
// Latency: log2(DATA_W) cycles, one word per cycle throughput.
// Backpressure: global stall when out_valid && !out_ready; in_ready drops, all stages hold.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data; out_valid/out_ready/
//        out_data/out_cnt; out_zero only when SHIFT_NORMALIZER_ZERO_FLAG_EN is defined.
module shift_normalizer
    import norm_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    localparam int CW     = cnt_w(DATA_W),
    localparam int NS     = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_cnt
`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
    ,
    output logic              out_zero
`endif
);

    logic              vld [NS+1];
    logic [DATA_W-1:0] dat [NS+1];
    logic [CW-1:0]     cnt [NS+1];
    logic              stall;

    // Reset overrides the stall so in_ready stays high while rst is asserted;
    // the stage registers are cleared by reset regardless of the enable.
    assign stall    = vld[NS] && !out_ready && !rst;
    assign in_ready = !stall;

    // Stage 0 captures in_valid whenever not stalled, which is exactly
    // in_valid && in_ready.
    assign vld[0] = in_valid;
    assign dat[0] = in_data;
    assign cnt[0] = '0;

    for (genvar k = 0; k < NS; k++) begin : g_stage
        norm_stage #(
            .DATA_W   (DATA_W),
            .CW       (CW),
            .SHIFT    (stage_shift(DATA_W, k)),
            .ZERO_FIX (k == NS - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (!stall),
            .in_valid  (vld[k]),
            .in_data   (dat[k]),
            .in_cnt    (cnt[k]),
            .out_valid (vld[k+1]),
            .out_data  (dat[k+1]),
            .out_cnt   (cnt[k+1])
        );
    end

    assign out_valid = vld[NS];
    assign out_data  = dat[NS];
    assign out_cnt   = cnt[NS];

`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
    // A count of DATA_W only arises from an all-zero source word; derived from
    // the output registers, so it is 0 after reset and holds through stalls.
    assign out_zero = out_valid && (out_cnt == CW'(DATA_W));
`endif

endmodule

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_cnt;
`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int total = 0;
    int bad   = 0;
    int n_in  = 0;
    int n_out = 0;
    logic [20:0] exp_q [$];

    shift_normalizer #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: scan from the MSB for the first one.
    function automatic logic [20:0] model(input logic [15:0] d);
        int          n;
        logic [15:0] s;
        n = 16;
        for (int i = 15; i >= 0; i--) begin
            if (d[i]) begin
                n = 15 - i;
                break;
            end
        end
        s = d << n;
        return {s, 5'(n)};
    endfunction

    // Scoreboard: push on input transfer, pop/compare on output transfer.
    always @(negedge clk) begin
        logic [20:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(out_data), 32'(e[20:5]));
                    check("sb_cnt", 32'(out_cnt), 32'(e[4:0]));
`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
                    check("sb_zero", 32'(out_zero), 32'(e[4:0] == 5'd16));
`endif
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back(model(in_data));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send(input logic [15:0] d);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                got = 1'b1;
                break;
            end
        end
        check("send_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for out_valid (out_ready assumed high), checks the word, consumes it.
    task automatic expect_out(input string tag, input logic [15:0] d, input logic [4:0] c,
                              output int waited);
        waited = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            waited++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_cnt"}, 32'(out_cnt), 32'(c));
`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
        check({tag, "_zero"}, 32'(out_zero), 32'(c == 5'd16));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          w;
        logic [15:0] held_d;
        logic [4:0]  held_c;
        logic        seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: presented in cycle c, out_valid in cycle c+4
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 16'h0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("lat_early_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h8000);
        check("lat_cnt", 32'(out_cnt), 32'd15);
        @(posedge clk);
        #1;

        // Single words: MSB already set, mid value, all zero
        send(16'h8000);
        expect_out("msb", 16'h8000, 5'd0, w);
        send(16'h00F0);
        expect_out("f0", 16'hF000, 5'd8, w);
        send(16'h0000);
        expect_out("zero", 16'h0000, 5'd16, w);

        // Back-to-back words must come out on consecutive cycles
        send(16'h0003);
        send(16'h0400);
        send(16'h7FFF);
        expect_out("b2b0", 16'hC000, 5'd14, w);
        expect_out("b2b1", 16'h8000, 5'd5, w);
        check("b2b1_gap", 32'(w), 32'd0);
        expect_out("b2b2", 16'hFFFE, 5'd1, w);
        check("b2b2_gap", 32'(w), 32'd0);

        // Stall: 4 words fill the pipe, a 5th waits at the input for 3 cycles
        out_ready = 1'b0;
        send(16'h0100);
        send(16'h0002);
        send(16'h4000);
        send(16'h0F0F);
        in_valid = 1'b1;
        in_data  = 16'h0000;
        held_d   = out_data;
        held_c   = out_cnt;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'(held_d));
            check("stall_out_cnt", 32'(out_cnt), 32'(held_c));
            @(posedge clk);
            #1;
        end
        check("stall_head_data", 32'(held_d), 32'h8000);
        check("stall_head_cnt", 32'(held_c), 32'd7);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("stall_drain", 32'(exp_q.size()), 32'd0);
        check("stall_io_count", 32'(n_out), 32'(n_in));
        @(posedge clk);
        #1;

        // Reset with two words in flight; input during reset is not accepted
        send(16'h1234);
        send(16'h0055);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_cnt", 32'(out_cnt), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        n_in  = 0;
        n_out = 0;

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        send(16'($urandom) >> $urandom_range(0, 16));
                    else
                        send(16'($urandom));
                end
            end
            begin
                repeat (120) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("rand_drain", 32'(exp_q.size()), 32'd0);
        check("rand_in_count", 32'(n_in), 32'd40);
        check("rand_out_count", 32'(n_out), 32'd40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
